// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: FIFO controller that keeps its storage in an external BRAM
// with a one-cycle read latency. Words are written straight into the BRAM on
// accept and prefetched into a 3-entry output buffer so the downstream side
// sees one word per cycle in steady state.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   s_valid/s_ready/s_data upstream stream (accept on s_valid && s_ready)
//   m_valid/m_ready/m_data downstream stream (pop on m_valid && m_ready)
//   w_valid/w_address/w_data    BRAM write port
//   ar_valid/ar_address         BRAM read request
//   r_valid/r_data              BRAM read response, one cycle after ar_valid
//   level                  words held in BRAM + in flight + output buffer
module bram_fifo_ctrl #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH-1:0]           s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_data,
    output logic                       w_valid,
    output logic [$clog2(DEPTH)-1:0]   w_address,
    output logic [WIDTH-1:0]           w_data,
    output logic                       ar_valid,
    output logic [$clog2(DEPTH)-1:0]   ar_address,
    input  logic                       r_valid,
    input  logic [WIDTH-1:0]           r_data,
    output logic [$clog2(DEPTH+4)-1:0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned LW = $clog2(DEPTH + 4);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    mem_count_q, mem_count_d;
    logic [1:0]       inflight_q, inflight_d;
    logic [1:0]       out_count_q, out_count_d;
    logic [LW-1:0]    level_q, level_d;
    logic             armed_q;
    logic [WIDTH-1:0] obuf_q [3];
    logic [WIDTH-1:0] obuf_d [3];

    logic       accept;
    logic       pop;
    logic       r_take;
    logic [2:0] occupied;
    logic [1:0] wr_idx;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Handshake and BRAM strobes, all gated only by registered state.
    always_comb begin
        occupied   = {1'b0, out_count_q} + {1'b0, inflight_q};
        s_ready    = (mem_count_q < CW'(DEPTH));
        // No BRAM write while held in reset even though s_ready reads 1.
        accept     = s_valid && s_ready && reset;
        w_valid    = accept;
        w_address  = wr_ptr_q;
        w_data     = s_data;
        ar_valid   = (mem_count_q != '0) && (occupied < 3'd3);
        ar_address = rd_ptr_q;
        m_valid    = (out_count_q != 2'd0);
        m_data     = obuf_q[0];
        pop        = m_valid && m_ready;
        // A response left over from before reset lands in the first cycle after release.
        r_take     = r_valid && armed_q;
        level      = level_q;
    end

    // Counter and pointer next-state.
    always_comb begin
        wr_ptr_d    = accept ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = ar_valid ? next_ptr(rd_ptr_q) : rd_ptr_q;

        mem_count_d = mem_count_q;
        unique case ({accept, ar_valid})
            2'b10:   mem_count_d = mem_count_q + CW'(1);
            2'b01:   mem_count_d = mem_count_q - CW'(1);
            default: mem_count_d = mem_count_q;
        endcase

        inflight_d = inflight_q;
        unique case ({ar_valid, r_take})
            2'b10:   inflight_d = inflight_q + 2'd1;
            2'b01:   inflight_d = inflight_q - 2'd1;
            default: inflight_d = inflight_q;
        endcase

        out_count_d = out_count_q;
        unique case ({r_take, pop})
            2'b10:   out_count_d = out_count_q + 2'd1;
            2'b01:   out_count_d = out_count_q - 2'd1;
            default: out_count_d = out_count_q;
        endcase

        level_d = LW'(mem_count_d) + LW'(inflight_d) + LW'(out_count_d);
    end

    // Output buffer as a shift register: entry 0 is always the oldest word,
    // so m_data holds still while the consumer stalls.
    always_comb begin
        obuf_d = obuf_q;
        wr_idx = out_count_q - {1'b0, pop};
        if (pop) begin
            obuf_d[0] = obuf_q[1];
            obuf_d[1] = obuf_q[2];
        end
        if (r_take && (wr_idx < 2'd3)) begin
            obuf_d[wr_idx] = r_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_count_q <= '0;
            inflight_q  <= 2'd0;
            out_count_q <= 2'd0;
            level_q     <= '0;
            armed_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_count_q <= mem_count_d;
            inflight_q  <= inflight_d;
            out_count_q <= out_count_d;
            level_q     <= level_d;
            armed_q     <= 1'b1;
        end
    end

    // Buffer contents are qualified by out_count and need no reset.
    always_ff @(posedge clk) begin
        obuf_q <= obuf_d;
    end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb_bram_fifo_ctrl: directed self-checking bench for bram_fifo_ctrl with
// WIDTH=8, DEPTH=4 and a one-cycle-latency BRAM model.
module tb_bram_fifo_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic             clk;
    logic             reset;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             w_valid;
    logic [1:0]       w_address;
    logic [WIDTH-1:0] w_data;
    logic             ar_valid;
    logic [1:0]       ar_address;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [2:0]       level;

    int checks = 0;
    int errors = 0;

    // BRAM model plus an injection path for a stray response.
    logic [WIDTH-1:0] bram [DEPTH];
    logic             bram_rv;
    logic [WIDTH-1:0] bram_rd;
    logic             inj_rv;
    logic [WIDTH-1:0] inj_data;

    bram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .w_valid    (w_valid),
        .w_address  (w_address),
        .w_data     (w_data),
        .ar_valid   (ar_valid),
        .ar_address (ar_address),
        .r_valid    (r_valid),
        .r_data     (r_data),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_valid) bram[w_address] <= w_data;
        bram_rv <= ar_valid;
        if (ar_valid) bram_rd <= bram[ar_address];
    end

    assign r_valid = bram_rv | inj_rv;
    assign r_data  = inj_rv ? inj_data : bram_rd;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; s_valid = 1'b1; s_data = 8'h11; m_ready = 1'b0;
        step(); step();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %0b want 1", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
        checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL reset_w_valid got %0b want 0", w_valid); end
        checks++; if (ar_valid !== 1'b0) begin errors++; $display("FAIL reset_ar_valid got %0b want 0", ar_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        s_valid = 1'b0;
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
        #1;
        checks++; if (w_valid !== 1'b1) begin errors++; $display("FAIL single_w_valid got %0b want 1", w_valid); end
        checks++; if (w_address !== 2'd0) begin errors++; $display("FAIL single_w_address got %0d want 0", w_address); end
        checks++; if (w_data !== 8'hA5) begin errors++; $display("FAIL single_w_data got %h want a5", w_data); end
        step();
        s_valid = 1'b0;
        #1;
        checks++; if (ar_valid !== 1'b1) begin errors++; $display("FAIL single_ar_valid got %0b want 1", ar_valid); end
        checks++; if (ar_address !== 2'd0) begin errors++; $display("FAIL single_ar_address got %0d want 0", ar_address); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level1 got %0d want 1", level); end
        step(); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_early_m_valid got %0b want 0", m_valid); end
        step(); #1;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_m_valid got %0b want 1", m_valid); end
        checks++; if (m_data !== 8'hA5) begin errors++; $display("FAIL single_m_data got %h want a5", m_data); end
        step(); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_after_m_valid got %0b want 0", m_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_level0 got %0d want 0", level); end
    endtask

    task automatic test_fill();
        int nxt;
        int expd;
        logic acc;
        nxt = 1;
        m_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            s_valid = (nxt <= 8);
            s_data  = 8'(nxt);
            #1;
            acc = s_valid && s_ready;
            step();
            if (acc) nxt++;
        end
        s_valid = 1'b0;
        #1;
        checks++; if (nxt - 1 != 7) begin errors++; $display("FAIL fill_accepted got %0d want 7", nxt - 1); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL fill_s_ready got %0b want 0", s_ready); end
        checks++; if (level !== 3'd7) begin errors++; $display("FAIL fill_level got %0d want 7", level); end
        m_ready = 1'b1;
        expd = 1;
        for (int c = 0; c < 30 && expd < 8; c++) begin
            #1;
            if (m_valid) begin
                checks++;
                if (m_data !== 8'(expd)) begin
                    errors++; $display("FAIL fill_order got %h want %h", m_data, 8'(expd));
                end
                expd++;
            end
            step();
        end
        checks++; if (expd != 8) begin errors++; $display("FAIL fill_drain_count got %0d want 7", expd - 1); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL fill_level_end got %0d want 0", level); end
    endtask

    task automatic test_stream();
        int first;
        int gaps;
        logic [7:0] expd;
        first = -1; gaps = 0; expd = 8'h40;
        s_valid = 1'b1; m_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            s_data = 8'(8'h40 + c);
            #1;
            if (m_valid) begin
                if (first < 0) first = c;
                checks++;
                if (m_data !== expd) begin errors++; $display("FAIL stream_order got %h want %h", m_data, expd); end
                expd++;
            end else if (first >= 0) begin
                gaps++;
            end
            step();
        end
        s_valid = 1'b0;
        checks++; if (first != 3) begin errors++; $display("FAIL stream_first got %0d want 3", first); end
        checks++; if (gaps != 0) begin errors++; $display("FAIL stream_gaps got %0d want 0", gaps); end
        checks++; if (expd !== 8'h6F) begin errors++; $display("FAIL stream_count got %h want 6f", expd); end
        for (int c = 0; c < 10 && expd != 8'h72; c++) begin
            #1;
            if (m_valid) begin
                checks++;
                if (m_data !== expd) begin errors++; $display("FAIL stream_tail got %h want %h", m_data, expd); end
                expd++;
            end
            step();
        end
        checks++; if (expd !== 8'h72) begin errors++; $display("FAIL stream_drain got %h want 72", expd); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL stream_level got %0d want 0", level); end
    endtask

    task automatic test_wrap();
        logic [39:0] pat;
        int nxt;
        int expd;
        logic acc;
        logic prev_stall;
        logic [7:0] prev_data;
        pat = 40'hB6D53A9CE1;
        nxt = 0; expd = 0; prev_stall = 1'b0; prev_data = 8'h00;
        for (int c = 0; c < 200 && expd < 20; c++) begin
            s_valid = (nxt < 20);
            s_data  = 8'(8'h80 + nxt);
            m_ready = pat[c % 40];
            #1;
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    errors++; $display("FAIL wrap_stall_stable got %0b/%h want 1/%h", m_valid, m_data, prev_data);
                end
            end
            acc = s_valid && s_ready;
            if (m_valid && m_ready) begin
                checks++;
                if (m_data !== 8'(8'h80 + expd)) begin
                    errors++; $display("FAIL wrap_order got %h want %h", m_data, 8'(8'h80 + expd));
                end
                expd++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            step();
            if (acc) nxt++;
        end
        s_valid = 1'b0; m_ready = 1'b1;
        checks++; if (expd != 20) begin errors++; $display("FAIL wrap_count got %0d want 20", expd); end
        #1;
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL wrap_level got %0d want 0", level); end
    endtask

    task automatic test_reset_mid();
        logic got;
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = 8'(8'h50 + i);
            step();
        end
        s_valid = 1'b0;
        #1;
        checks++; if (level !== 3'd5) begin errors++; $display("FAIL mid_level_before got %0d want 5", level); end
        reset = 1'b0;
        #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL mid_s_ready got %0b want 1", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_m_valid got %0b want 0", m_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_level got %0d want 0", level); end
        step(); step();
        reset = 1'b1;
        inj_rv = 1'b1; inj_data = 8'hEE;
        step();
        inj_rv = 1'b0;
        #1;
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_stray_level got %0d want 0", level); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_stray_m_valid got %0b want 0", m_valid); end
        s_valid = 1'b1; s_data = 8'h3C; m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            #1;
            if (m_valid) begin
                got = 1'b1;
                checks++;
                if (m_data !== 8'h3C) begin errors++; $display("FAIL mid_first_word got %h want 3c", m_data); end
            end
            step();
        end
        checks++; if (!got) begin errors++; $display("FAIL mid_timeout got none want 3c"); end
    endtask

    initial begin
        reset = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        inj_rv = 1'b0; inj_data = '0;
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_fifo_ctrl.md
BRAM_FIFO_CTRL -- requirements
Module: bram_fifo_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 10, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 10, BRAM entries; any integer >= 2, not required to be a power of two.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; the block is in reset while reset=0.
REQ-005 s_valid  input  1  upstream word offered.
REQ-006 s_ready  output  1  upstream word accepted when s_valid && s_ready.
REQ-007 s_data  input  WIDTH  upstream word.
REQ-008 m_valid  output  1  downstream word offered.
REQ-009 m_ready  input  1  downstream word consumed when m_valid && m_ready.
REQ-010 m_data  output  WIDTH  downstream word.
REQ-011 w_valid  output  1  BRAM write strobe.
REQ-012 w_address  output  $clog2(DEPTH)  BRAM write address.
REQ-013 w_data  output  WIDTH  BRAM write data.
REQ-014 ar_valid  output  1  BRAM read request.
REQ-015 ar_address  output  $clog2(DEPTH)  BRAM read address.
REQ-016 r_valid  input  1  BRAM read data valid, one cycle after ar_valid.
REQ-017 r_data  input  WIDTH  BRAM read data.
REQ-018 level  output  $clog2(DEPTH+4)  total words held (BRAM + in flight + output buffer).

Function
REQ-019 SHALL be a FIFO: words leave m_data in exactly the order accepted on s_data, none lost or duplicated.
REQ-020 SHALL keep wr_ptr, rd_ptr (0..DEPTH-1) and mem_count (0..DEPTH); pointers wrap DEPTH-1 -> 0.
REQ-021 s_ready SHALL equal (mem_count < DEPTH), from registered state only; no combinational path from s_valid or m_ready.
REQ-022 On accept: w_valid=1, w_address=wr_ptr, w_data=s_data combinationally in the same cycle; wr_ptr advances at that edge.
REQ-023 w_valid SHALL be 0 whenever no upstream accept occurs.
REQ-024 SHALL hold a 3-entry output buffer (out_count 0..3) and an in-flight counter (0..3, incremented on ar_valid, decremented on r_valid).
REQ-025 ar_valid SHALL equal (mem_count > 0) && (out_count + inflight < 3), registered state only; ar_address=rd_ptr; rd_ptr advances on ar_valid.
REQ-026 r_data SHALL be written into the output buffer at every edge where r_valid=1.
REQ-027 m_valid SHALL equal (out_count > 0); m_data SHALL be the oldest buffered word, stable while m_valid && !m_ready.
REQ-028 mem_count: +1 on accept only, -1 on ar_valid only, unchanged when both occur in the same cycle.
REQ-029 out_count: +1 on r_valid only, -1 on pop only, unchanged when both.
REQ-030 A read SHALL never target a word written in the same cycle (mem_count is registered), so BRAM read-during-write behaviour is irrelevant.
REQ-031 Latency: word accepted at edge N appears on m_valid in cycle N+3 when FIFO empty and m_ready=1.
REQ-032 Throughput: with s_valid=1, m_ready=1 continuously, one word per cycle in steady state.
REQ-033 Capacity: DEPTH+3 words; s_ready=0 exactly when mem_count=DEPTH.
REQ-034 level SHALL equal mem_count + inflight + out_count, registered.

Reset
REQ-035 reset=0 SHALL asynchronously clear wr_ptr, rd_ptr, mem_count, inflight, out_count, level to 0; s_ready=1, m_valid=0, w_valid=0, ar_valid=0.
REQ-036 Reset mid-operation SHALL discard all held and in-flight words; any r_valid arriving in the first cycle after reset release SHALL be ignored.
REQ-037 Output-buffer data contents need not be reset.

Verification (WIDTH=8, DEPTH=4, BRAM model with 1-cycle read)
REQ-038 Single word: push 0xA5 into empty FIFO, m_ready=1 -> ar_valid in cycle +1, m_valid with m_data=0xA5 in cycle +3, level returns to 0.
REQ-039 Fill: m_ready=0, push 0x01..0x08 continuously -> exactly 7 accepted, s_ready=0 after 7th, level=7; then m_ready=1 -> 0x01..0x07 out in order.
REQ-040 Streaming: s_valid=1, m_ready=1 for 50 cycles with incrementing data -> after 3-cycle fill, m_valid=1 every cycle, no gaps, order preserved.
REQ-041 Wrap: 20 words with random m_ready stalls -> pointers wrap past 3 multiple times, output sequence exact, m_data stable during stalls.
REQ-042 Reset mid-stream: assert reset=0 with level=5 -> s_ready=1, m_valid=0, level=0 immediately; next push 0x3C is the first word out.
